multiplexor_7seg_n_digitos: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display fed with packed BCD digits.

---
 rtl/multiplexor_7seg_n_digitos.sv | 146 ++++++++++++++
 tb/tb_multiplexor_7seg_n_digitos.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_7seg_n_digitos.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans one packed-BCD digit per refresh slot, decodes it to active-low
// {a,b,c,d,e,f,g,dp}, applies leading-zero suppression and per-digit decimal
// points, keeps all anodes dark for TIEMPO_MUERTO cycles at each slot start,
// and only samples the inputs at frame boundaries so a frame never tears.
//
// Ports:
//   clk            rising-edge system clock
//   rst_n          asynchronous reset, active-low
//   habilitar      1: scan, 0: display dark and scan held at digit 0
//   suprimir_ceros 1: blank leading zeros (digit 0 is never blanked)
//   cifras         BCD digits, [3:0] = digit 0 (rightmost)
//   puntos         decimal point request per digit, 1 = lit
//   cod7SEG        registered segments {a..g,dp}, active-low
//   anodos         registered digit select, polarity set by ANODO_BAJO
//   fin_trama      one-cycle pulse after the last slot of a frame ends
module multiplexor_7seg_n_digitos #(
  parameter int unsigned N_DIGITOS     = 4,
  parameter int unsigned DIV_REFRESCO  = 50000,
  parameter int unsigned TIEMPO_MUERTO = 500,
  parameter int unsigned ANODO_BAJO    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     habilitar,
  input  logic                     suprimir_ceros,
  input  logic [4*N_DIGITOS-1:0]   cifras,
  input  logic [N_DIGITOS-1:0]     puntos,
  output logic [7:0]               cod7SEG,
  output logic [N_DIGITOS-1:0]     anodos,
  output logic                     fin_trama
);

  localparam int unsigned CW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam int unsigned IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(DIV_REFRESCO - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(N_DIGITOS - 1);
  localparam logic [CW-1:0] CNT_MUERTO = CW'(TIEMPO_MUERTO);
  localparam logic [N_DIGITOS-1:0] AN_OFF = (ANODO_BAJO != 0) ? '1 : '0;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] sh_cif_q, sh_cif_d;
  logic [N_DIGITOS-1:0]   sh_pun_q, sh_pun_d;
  logic                   hab_prev_q, hab_prev_d;
  logic [7:0]             cod_q, cod_d;
  logic [N_DIGITOS-1:0]   an_q, an_d;
  logic                   fin_q, fin_d;

  logic                   tick, wrap, carga;
  logic                   run;
  logic [N_DIGITOS-1:0]   cero_lider;
  logic [3:0]             digito;
  logic                   punto, suprimido;
  logic [6:0]             segs;
  logic [N_DIGITOS-1:0]   sel;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tick = habilitar && (cnt_q == CNT_MAX);
    wrap = tick && (idx_q == IDX_MAX);

    cnt_d = '0;
    idx_d = '0;
    if (habilitar) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
        idx_d = wrap ? '0 : idx_q + 1'b1;
      end
    end

    // Shadow reloads at frame start and on the first enabled edge, so the
    // digit decoded on that same edge already comes from the fresh values.
    hab_prev_d = habilitar;
    carga      = habilitar && (wrap || !hab_prev_q);
    sh_cif_d   = carga ? cifras : sh_cif_q;
    sh_pun_d   = carga ? puntos : sh_pun_q;
    fin_d      = wrap;

    // cero_lider[i]: digits N-1..i are all zero and carry no decimal point.
    cero_lider = '0;
    run        = 1'b1;
    for (int unsigned j = 0; j < N_DIGITOS; j++) begin
      run = run & (sh_cif_d[4*(N_DIGITOS-1-j) +: 4] == 4'd0)
                & ~sh_pun_d[N_DIGITOS-1-j];
      cero_lider[N_DIGITOS-1-j] = run;
    end

    digito    = 4'(sh_cif_d >> {idx_d, 2'b00});
    punto     = 1'(sh_pun_d >> idx_d);
    suprimido = suprimir_ceros && (idx_d != '0) && 1'(cero_lider >> idx_d);
    segs      = suprimido ? 7'b1111111 : seg7(digito);
    cod_d     = habilitar ? {segs, ~punto} : 8'hFF;

    sel  = N_DIGITOS'(1) << idx_d;
    an_d = AN_OFF;
    if (habilitar && (cnt_d >= CNT_MUERTO)) begin
      an_d = (ANODO_BAJO != 0) ? ~sel : sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_cif_q   <= '1;
      sh_pun_q   <= '0;
      hab_prev_q <= 1'b0;
      cod_q      <= 8'hFF;
      an_q       <= AN_OFF;
      fin_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_cif_q   <= sh_cif_d;
      sh_pun_q   <= sh_pun_d;
      hab_prev_q <= hab_prev_d;
      cod_q      <= cod_d;
      an_q       <= an_d;
      fin_q      <= fin_d;
    end
  end

  assign cod7SEG   = cod_q;
  assign anodos    = an_q;
  assign fin_trama = fin_q;

endmodule

// File: tb/tb_multiplexor_7seg_n_digitos.sv
module tb_multiplexor_7seg_n_digitos;

  localparam int NI = 3;
  // Instance 0: N=4 DIV=4 TM=1 active-low; 1: N=1 DIV=4 TM=0 active-low;
  // 2: N=4 DIV=5 TM=2 active-high.
  int unsigned p_n   [NI] = '{4, 1, 4};
  int unsigned p_div [NI] = '{4, 4, 5};
  int unsigned p_tm  [NI] = '{1, 0, 2};
  bit          p_ab  [NI] = '{1'b1, 1'b1, 1'b0};

  localparam logic [6:0] SEGS [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000,
    7'b0000100};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        habilitar = 1'b0;
  logic        suprimir_ceros = 1'b0;
  logic [15:0] cifras = '0;
  logic [3:0]  puntos = '0;

  logic [7:0] cod_a, cod_b, cod_c;
  logic [3:0] an_a, an_c;
  logic [0:0] an_b;
  logic       fin_a, fin_b, fin_c;

  int n_chk = 0;
  int n_fail = 0;
  int ciclos = 0;
  int base = 0;

  // Model state: m_e = enabled edges since the scan (re)started.
  int unsigned m_e   [NI];
  logic [31:0] m_sc  [NI];
  logic [7:0]  m_sp  [NI];
  logic [7:0]  x_cod [NI];
  logic [7:0]  x_an  [NI];
  logic        x_fin [NI];

  multiplexor_7seg_n_digitos #(.N_DIGITOS(4), .DIV_REFRESCO(4), .TIEMPO_MUERTO(1), .ANODO_BAJO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .suprimir_ceros(suprimir_ceros),
    .cifras(cifras), .puntos(puntos), .cod7SEG(cod_a), .anodos(an_a), .fin_trama(fin_a));

  multiplexor_7seg_n_digitos #(.N_DIGITOS(1), .DIV_REFRESCO(4), .TIEMPO_MUERTO(0), .ANODO_BAJO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .suprimir_ceros(suprimir_ceros),
    .cifras(cifras[3:0]), .puntos(puntos[0]), .cod7SEG(cod_b), .anodos(an_b), .fin_trama(fin_b));

  multiplexor_7seg_n_digitos #(.N_DIGITOS(4), .DIV_REFRESCO(5), .TIEMPO_MUERTO(2), .ANODO_BAJO(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .suprimir_ceros(suprimir_ceros),
    .cifras(cifras), .puntos(puntos), .cod7SEG(cod_c), .anodos(an_c), .fin_trama(fin_c));

  always #5 clk = ~clk;

  task automatic chk(input string nom, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nom, act, exp, $time);
    end
  endtask

  task automatic lit(input string nom, input logic [7:0] act, input logic [7:0] modelo,
                     input logic [7:0] exp);
    chk(nom, act, exp);
    chk({nom, "_ref"}, modelo, exp);
  endtask

  // Highest position holding a nonzero digit or a point; anything above it is
  // a leading zero.
  function automatic logic [7:0] glifo(input int k, input int d, input logic sup);
    int         h;
    logic [3:0] v;
    logic [6:0] s;
    h = -1;
    for (int j = 0; j < int'(p_n[k]); j++)
      if (m_sc[k][4*j +: 4] != 4'd0 || m_sp[k][j]) h = j;
    v = m_sc[k][4*d +: 4];
    if (v > 4'd9 || (sup && d > 0 && d > h)) s = 7'b1111111;
    else s = SEGS[v];
    return {s, ~m_sp[k][d]};
  endfunction

  task automatic modelo_paso(input int k, input logic rst, input logic hab, input logic sup,
                             input logic [31:0] cif, input logic [7:0] pun);
    logic [31:0] mcif;
    logic [7:0]  mpun, sel, apag;
    int unsigned p, trama, d, fase;
    mcif = '0; mpun = '0; apag = '0;
    for (int j = 0; j < int'(p_n[k]); j++) begin
      mcif[4*j +: 4] = cif[4*j +: 4];
      mpun[j] = pun[j];
      apag[j] = p_ab[k];
    end
    if (!rst) begin
      m_e[k] = 0; m_sc[k] = '1; m_sp[k] = '0;
      x_cod[k] = 8'hFF; x_an[k] = apag; x_fin[k] = 1'b0;
    end else if (!hab) begin
      m_e[k] = 0;
      x_cod[k] = 8'hFF; x_an[k] = apag; x_fin[k] = 1'b0;
    end else begin
      m_e[k]++;
      p = m_e[k];
      trama = p_n[k] * p_div[k];
      if (p == 1 || p % trama == 0) begin
        m_sc[k] = mcif; m_sp[k] = mpun;
      end
      d    = (p / p_div[k]) % p_n[k];
      fase = p % p_div[k];
      x_fin[k] = (p % trama == 0);
      x_cod[k] = glifo(k, int'(d), sup);
      sel = 8'd1 << d;
      if (fase < p_tm[k]) x_an[k] = apag;
      else x_an[k] = p_ab[k] ? (apag & ~sel) : sel;
    end
  endtask

  // Per-cycle compare of every instance against the model.
  initial begin
    forever begin
      @(posedge clk);
      ciclos++;
      for (int k = 0; k < NI; k++)
        modelo_paso(k, rst_n, habilitar, suprimir_ceros, {16'h0, cifras}, {4'h0, puntos});
      #1;
      chk("cod_a", cod_a, x_cod[0]);
      chk("an_a", {4'h0, an_a}, x_an[0]);
      chk("fin_a", {7'h0, fin_a}, {7'h0, x_fin[0]});
      chk("cod_b", cod_b, x_cod[1]);
      chk("an_b", {7'h0, an_b}, x_an[1]);
      chk("fin_b", {7'h0, fin_b}, {7'h0, x_fin[1]});
      chk("cod_c", cod_c, x_cod[2]);
      chk("an_c", {4'h0, an_c}, x_an[2]);
      chk("fin_c", {7'h0, fin_c}, {7'h0, x_fin[2]});
    end
  end

  task automatic hasta(input int k);
    while (ciclos < base + k) @(negedge clk);
  endtask

  task automatic reiniciar(input logic [15:0] c, input logic [3:0] p, input logic s);
    @(negedge clk);
    habilitar = 1'b0;
    @(negedge clk);
    cifras = c; puntos = p; suprimir_ceros = s; habilitar = 1'b1;
    base = ciclos;
  endtask

  function automatic logic [15:0] rnd_cifras();
    logic [15:0] c;
    int unsigned r;
    for (int j = 0; j < 4; j++) begin
      r = $urandom_range(0, 9);
      if (r < 5) c[4*j +: 4] = 4'd0;
      else if (r < 9) c[4*j +: 4] = 4'($urandom_range(1, 9));
      else c[4*j +: 4] = 4'($urandom_range(10, 15));
    end
    return c;
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    lit("rst_cod_a", cod_a, x_cod[0], 8'hFF);
    lit("rst_an_a", {4'h0, an_a}, x_an[0], 8'h0F);
    lit("rst_an_c", {4'h0, an_c}, x_an[2], 8'h00);
    lit("rst_fin_a", {7'h0, fin_a}, {7'h0, x_fin[0]}, 8'h00);
    rst_n = 1'b1;

    // Plain scan of 1234
    cifras = 16'h1234; puntos = 4'h0; suprimir_ceros = 1'b0; habilitar = 1'b1;
    base = ciclos;
    hasta(1);
    lit("scan_e1_an_a", {4'h0, an_a}, x_an[0], 8'h0E);
    lit("scan_e1_cod_a", cod_a, x_cod[0], 8'h99);
    lit("scan_e1_an_c", {4'h0, an_c}, x_an[2], 8'h00);
    lit("scan_e1_an_b", {7'h0, an_b}, x_an[1], 8'h00);
    lit("scan_e1_cod_b", cod_b, x_cod[1], 8'h99);
    hasta(2);
    lit("scan_e2_an_c", {4'h0, an_c}, x_an[2], 8'h01);
    hasta(4);
    lit("scan_e4_an_a", {4'h0, an_a}, x_an[0], 8'h0F);
    lit("scan_e4_cod_a", cod_a, x_cod[0], 8'h0D);
    lit("scan_e4_fin_b", {7'h0, fin_b}, {7'h0, x_fin[1]}, 8'h01);
    hasta(5);
    lit("scan_e5_an_a", {4'h0, an_a}, x_an[0], 8'h0D);
    lit("scan_e5_fin_b", {7'h0, fin_b}, {7'h0, x_fin[1]}, 8'h00);
    lit("scan_e5_cod_c", cod_c, x_cod[2], 8'h0D);
    hasta(8);
    lit("scan_e8_cod_a", cod_a, x_cod[0], 8'h25);
    hasta(9);
    lit("scan_e9_an_a", {4'h0, an_a}, x_an[0], 8'h0B);
    hasta(13);
    lit("scan_e13_cod_a", cod_a, x_cod[0], 8'h9F);
    lit("scan_e13_an_a", {4'h0, an_a}, x_an[0], 8'h07);
    hasta(15);
    lit("scan_e15_fin_a", {7'h0, fin_a}, {7'h0, x_fin[0]}, 8'h00);
    hasta(16);
    lit("scan_e16_fin_a", {7'h0, fin_a}, {7'h0, x_fin[0]}, 8'h01);
    lit("scan_e16_cod_a", cod_a, x_cod[0], 8'h99);
    hasta(17);
    lit("scan_e17_fin_a", {7'h0, fin_a}, {7'h0, x_fin[0]}, 8'h00);

    // Asynchronous reset mid-slot, no clock edge needed
    hasta(19);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cod_a", cod_a, 8'hFF);
    chk("arst_an_a", {4'h0, an_a}, 8'h0F);
    chk("arst_an_c", {4'h0, an_c}, 8'h00);
    chk("arst_an_b", {7'h0, an_b}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    base = ciclos;
    #1 chk("arst_rel_an_a", {4'h0, an_a}, 8'h0F);
    hasta(1);
    lit("arst_e1_an_a", {4'h0, an_a}, x_an[0], 8'h0E);
    lit("arst_e1_cod_a", cod_a, x_cod[0], 8'h99);

    // Leading-zero suppression
    reiniciar(16'h0070, 4'b0000, 1'b1);
    hasta(1);  lit("sup_d0", cod_a, x_cod[0], 8'h03);
    hasta(4);  lit("sup_d1", cod_a, x_cod[0], 8'h1F);
    hasta(8);  lit("sup_d2", cod_a, x_cod[0], 8'hFF);
    hasta(12); lit("sup_d3", cod_a, x_cod[0], 8'hFF);
    reiniciar(16'h0070, 4'b0100, 1'b1);
    hasta(4);  lit("supdp_d1", cod_a, x_cod[0], 8'h1F);
    hasta(8);  lit("supdp_d2", cod_a, x_cod[0], 8'h02);
    hasta(12); lit("supdp_d3", cod_a, x_cod[0], 8'hFF);

    // Input change mid-frame must wait for the next frame
    reiniciar(16'h1111, 4'b0000, 1'b0);
    hasta(5);  cifras = 16'h2222;
    hasta(8);  lit("tear_d2", cod_a, x_cod[0], 8'h9F);
    hasta(12); lit("tear_d3", cod_a, x_cod[0], 8'h9F);
    hasta(16); lit("tear_n0", cod_a, x_cod[0], 8'h25);
    hasta(20); lit("tear_n1", cod_a, x_cod[0], 8'h25);

    // Invalid digits, then disable mid-slot
    reiniciar(16'hFA00, 4'b0000, 1'b0);
    hasta(1);  lit("inv_d0", cod_a, x_cod[0], 8'h03);
    hasta(8);  lit("inv_d2", cod_a, x_cod[0], 8'hFF);
    hasta(12); lit("inv_d3", cod_a, x_cod[0], 8'hFF);
    hasta(14);
    habilitar = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      hasta(14 + i);
      lit("dis_cod_a", cod_a, x_cod[0], 8'hFF);
      lit("dis_an_a", {4'h0, an_a}, x_an[0], 8'h0F);
    end
    habilitar = 1'b1;
    base = ciclos;
    hasta(1); lit("reen_e1_an_a", {4'h0, an_a}, x_an[0], 8'h0E);
    hasta(3); lit("reen_e3_an_a", {4'h0, an_a}, x_an[0], 8'h0E);
    hasta(4); lit("reen_e4_an_a", {4'h0, an_a}, x_an[0], 8'h0F);

    // Randomised traffic
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) cifras = rnd_cifras();
      if ($urandom_range(0, 19) == 0) puntos = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) suprimir_ceros = ~suprimir_ceros;
      if (habilitar && $urandom_range(0, 99) == 0) habilitar = 1'b0;
      else if (!habilitar && $urandom_range(0, 2) == 0) habilitar = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
